instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 36 +++
 rtl/instr_loader_if.sv | 30 +++
 rtl/instr_loader_asm.sv | 42 ++++
 rtl/instr_loader.sv | 153 +++++++++++++++
 tb/tb_instr_loader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the serial instruction loader.
// The CHK state exists only when INSTR_LOADER_CHECKSUM_EN is defined.
package instr_loader_pkg;

   localparam int DEFAULT_DEPTH = 32;
   localparam int BYTE_LANES    = 4;

`ifdef INSTR_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_LEN, ST_DATA, ST_WRITE, ST_CHK, ST_DONE, ST_ERR
   } loader_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_LEN, ST_DATA, ST_WRITE, ST_DONE, ST_ERR
   } loader_state_t;
`endif

   // States in which the serial side may hand over a byte.
   function automatic logic isReadyState(input loader_state_t s);
      logic ready;
      ready = (s == ST_LEN) || (s == ST_DATA);
`ifdef INSTR_LOADER_CHECKSUM_EN
      ready = ready || (s == ST_CHK);
`endif
      return ready;
   endfunction

   function automatic logic isBusyState(input loader_state_t s);
      return isReadyState(s) || (s == ST_WRITE);
   endfunction

   function automatic logic isCoreRstState(input loader_state_t s);
      return (s != ST_IDLE) && (s != ST_DONE);
   endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Bundle of the loader's control, serial-byte and instruction-memory signals.
// master = host/serial side and observer, slave = the loader itself.
interface instr_loader_if #(parameter int AW = 5);

   logic          start;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   word_count;

   modport master (
      output start, byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata,
      input  core_rst, busy, done, error, word_count
   );

   modport slave (
      input  start, byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata,
      output core_rst, busy, done, error, word_count
   );

endinterface

// File: rtl/instr_loader_asm.sv
// Little-endian 8-to-32 byte assembler: first byte of a word lands in [7:0].
// o_word already contains the byte being accepted this cycle.
module instr_loader_asm
   import instr_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_byteEn,
   input  logic [7:0]  i_byteData,
   output logic [31:0] o_word,
   output logic        o_wordComplete
);

   localparam int LANE_W = $clog2(BYTE_LANES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTE_LANES - 1);
   localparam logic [LANE_W-1:0] LANE_STEP = LANE_W'(1);

   logic [LANE_W-1:0] r_lane;
   logic [31:0]       r_word;
   logic [31:0]       w_merged;

   always_comb begin
      w_merged = r_word;
      w_merged[r_lane*8 +: 8] = i_byteData;
   end

   assign o_word         = w_merged;
   assign o_wordComplete = i_byteEn && (r_lane == LAST_LANE);

   // The lane counter wraps naturally after the fourth byte.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_lane <= '0;
         r_word <= '0;
      end else if (i_byteEn) begin
         r_lane <= r_lane + LANE_STEP;
         r_word <= w_merged;
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Serial instruction loader: receives N, then 4*N little-endian bytes, and
// writes N words to imem from address 0. Checksum option: INSTR_LOADER_CHECKSUM_EN.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   instr_loader_if.slave  bus
);

   localparam logic [8:0]  DEPTH_LIM = 9'(DEPTH);
   localparam logic [AW:0] ONE_WORD  = (AW+1)'(1);

   loader_state_t r_state;
   logic          r_byteReady;
   logic          r_busy;
   logic          r_done;
   logic          r_error;
   logic          r_coreRst;
   logic          r_imemWe;
   logic [AW-1:0] r_imemAddr;
   logic [31:0]   r_imemWdata;
   logic [AW:0]   r_wordCount;
   logic [AW:0]   r_wordTotal;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]    r_checksum;
`endif

   logic          w_transfer;
   logic          w_startAccept;
   logic          w_dataByte;
   logic [31:0]   w_asmWord;
   logic          w_wordComplete;
   logic [AW:0]   w_countNext;
   logic          w_lenBad;

   assign w_transfer    = bus.byte_valid && r_byteReady;
   assign w_startAccept = bus.start &&
                          ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
   assign w_dataByte    = (r_state == ST_DATA) && w_transfer;
   assign w_countNext   = r_wordCount + ONE_WORD;
   assign w_lenBad      = (bus.byte_data == 8'd0) || ({1'b0, bus.byte_data} > DEPTH_LIM);

   instr_loader_asm u_asm (
      .clk            (clk),
      .rst            (rst),
      .i_clear        (w_startAccept),
      .i_byteEn       (w_dataByte),
      .i_byteData     (bus.byte_data),
      .o_word         (w_asmWord),
      .o_wordComplete (w_wordComplete)
   );

   // All status flags are registered from the state being entered, so they
   // change on the same edge as the state itself.
   task automatic enterState(input loader_state_t s);
      r_state     <= s;
      r_byteReady <= isReadyState(s);
      r_busy      <= isBusyState(s);
      r_done      <= (s == ST_DONE);
      r_error     <= (s == ST_ERR);
      r_coreRst   <= isCoreRstState(s);
   endtask

   always_ff @(posedge clk) begin
      if (rst) begin
         enterState(ST_IDLE);
         r_imemWe    <= 1'b0;
         r_imemAddr  <= '0;
         r_imemWdata <= '0;
         r_wordCount <= '0;
         r_wordTotal <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         r_checksum  <= '0;
`endif
      end else begin
         r_imemWe <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (w_startAccept) begin
                  enterState(ST_LEN);
                  r_wordCount <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                  r_checksum  <= '0;
`endif
               end
            end
            ST_LEN: begin
               if (w_transfer) begin
                  if (w_lenBad) begin
                     enterState(ST_ERR);
                  end else begin
                     r_wordTotal <= (AW+1)'(bus.byte_data);
                     enterState(ST_DATA);
                  end
               end
            end
            ST_DATA: begin
               if (w_transfer) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  r_checksum <= r_checksum ^ bus.byte_data;
`endif
                  // Launch the write with the word including the byte just taken.
                  if (w_wordComplete) begin
                     r_imemWe    <= 1'b1;
                     r_imemAddr  <= r_wordCount[AW-1:0];
                     r_imemWdata <= w_asmWord;
                     enterState(ST_WRITE);
                  end
               end
            end
            ST_WRITE: begin
               r_wordCount <= w_countNext;
               if (w_countNext == r_wordTotal) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  enterState(ST_CHK);
`else
                  enterState(ST_DONE);
`endif
               end else begin
                  enterState(ST_DATA);
               end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (w_transfer) begin
                  if (bus.byte_data == r_checksum) begin
                     enterState(ST_DONE);
                  end else begin
                     enterState(ST_ERR);
                  end
               end
            end
`endif
            default: enterState(ST_IDLE);
         endcase
      end
   end

   assign bus.byte_ready = r_byteReady;
   assign bus.imem_we    = r_imemWe;
   assign bus.imem_addr  = r_imemAddr;
   assign bus.imem_wdata = r_imemWdata;
   assign bus.core_rst   = r_coreRst;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.error      = r_error;
   assign bus.word_count = r_wordCount;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected imem writes are queued at stimulus
// time and popped by a monitor whenever imem_we is seen.
module tb_instr_loader;
   import instr_loader_pkg::*;

   localparam int DEPTH = DEFAULT_DEPTH;
   localparam int AW    = $clog2(DEPTH);
`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam int CSUM_CYCLES = 1;
`else
   localparam int CSUM_CYCLES = 0;
`endif

   typedef struct {
      int          addr;
      logic [31:0] data;
   } write_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   instr_loader_if #(.AW(AW)) bus ();

   instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   write_t      expQ[$];
   logic [31:0] prog[$];
   int          vectorCount = 0;
   int          missCount   = 0;
   int          busyCycles  = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Pops one expected write for every imem_we cycle and tallies busy cycles.
   task automatic monitorLoop();
      write_t e;
      forever begin
         @(negedge clk);
         if (bus.busy === 1'b1) busyCycles++;
         if (bus.imem_we === 1'b1) begin
            if (expQ.size() == 0) begin
               vectorCount++;
               missCount++;
               $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                        bus.imem_addr, bus.imem_wdata);
            end else begin
               e = expQ.pop_front();
               checkOutput("write_addr", 32'(bus.imem_addr), e.addr[31:0]);
               checkOutput("write_data", bus.imem_wdata, e.data);
            end
         end
      end
   endtask

   // Offers one byte and holds it until a cycle with byte_ready takes it.
   task automatic applyStimulus(input logic [7:0] b, input bit gap);
      int t;
      bit seen;
      t = 0;
      seen = 1'b0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (!seen && t < 50) begin
         @(negedge clk);
         if (bus.byte_ready === 1'b1) seen = 1'b1;
         else t++;
      end
      if (!seen) begin
         vectorCount++;
         missCount++;
         $display("[TB] FAIL byte_timeout: got no byte_ready in 50 cycles, expected ready for 0x%0h", b);
         bus.byte_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         bus.byte_valid = 1'b0;
         if (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic startLoad();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Sends N, the words of prog (queuing each expected write) and, when built
   // with the checksum, the XOR of all data bytes.
   task automatic loadProgram(input bit gap);
      logic [7:0] csum;
      logic [31:0] w;
      write_t e;
      csum = 8'h00;
      applyStimulus(8'(prog.size()), gap);
      for (int i = 0; i < prog.size(); i++) begin
         w = prog[i];
         e.addr = i;
         e.data = w;
         expQ.push_back(e);
         for (int l = 0; l < 4; l++) begin
            csum = csum ^ w[8*l +: 8];
            applyStimulus(w[8*l +: 8], gap);
         end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      applyStimulus(csum, gap);
`else
      if (csum == 8'hxx) $display("[TB] note: unreachable");
`endif
   endtask

   task automatic waitEnd(input int budget, output bit sawDone, output bit sawErr, output logic prevCore);
      int t;
      t = 0;
      sawDone  = 1'b0;
      sawErr   = 1'b0;
      prevCore = bus.core_rst;
      while (!sawDone && !sawErr && t < budget) begin
         @(negedge clk);
         if (bus.done === 1'b1) sawDone = 1'b1;
         else if (bus.error === 1'b1) sawErr = 1'b1;
         else begin
            prevCore = bus.core_rst;
            t++;
         end
      end
      if (!sawDone && !sawErr) begin
         vectorCount++;
         missCount++;
         $display("[TB] FAIL end_timeout: got neither done nor error in %0d cycles, expected one", budget);
      end
      #1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
      checkOutput({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
      checkOutput({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
      checkOutput({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
      checkOutput({tag, "_core_rst"},   32'(bus.core_rst),   32'd0);
      checkOutput({tag, "_busy"},       32'(bus.busy),       32'd0);
      checkOutput({tag, "_done"},       32'(bus.done),       32'd0);
      checkOutput({tag, "_error"},      32'(bus.error),      32'd0);
      checkOutput({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
   endtask

   initial begin
      bit sawDone, sawErr;
      logic prevCore;
      int base;
      write_t e;

      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      fork
         monitorLoop();
      join_none

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk);
      #1;

      // Single word 0x00100513 sent as 01,13,05,10,00.
      $display("[TB] single-word load");
      prog = '{32'h0010_0513};
      base = busyCycles;
      startLoad();
      checkOutput("len_busy",     32'(bus.busy),       32'd1);
      checkOutput("len_core_rst", 32'(bus.core_rst),   32'd1);
      checkOutput("len_ready",    32'(bus.byte_ready), 32'd1);
      loadProgram(1'b0);
      waitEnd(100, sawDone, sawErr, prevCore);
      checkOutput("single_done",        32'(sawDone),        32'd1);
      checkOutput("single_core_rst",    32'(bus.core_rst),   32'd0);
      checkOutput("single_core_before", 32'(prevCore),       32'd1);
      checkOutput("single_word_count",  32'(bus.word_count), 32'd1);
      checkOutput("single_latency",     32'(busyCycles - base), 32'(1 + 5 * 1 + CSUM_CYCLES));

      // Three words with byte_valid dropped every other cycle.
      $display("[TB] gapped three-word load");
      prog = '{32'h1122_3344, 32'hDEAD_BEEF, 32'h8000_0001};
      startLoad();
      loadProgram(1'b1);
      waitEnd(200, sawDone, sawErr, prevCore);
      checkOutput("gap_done",       32'(sawDone),        32'd1);
      checkOutput("gap_word_count", 32'(bus.word_count), 32'd3);
      checkOutput("gap_queue_left", 32'(expQ.size()),    32'd0);

      // Illegal lengths: zero and DEPTH+1.
      $display("[TB] illegal length bytes");
      startLoad();
      applyStimulus(8'h00, 1'b0);
      checkOutput("len0_error",    32'(bus.error),      32'd1);
      checkOutput("len0_core_rst", 32'(bus.core_rst),   32'd1);
      checkOutput("len0_busy",     32'(bus.busy),       32'd0);
      checkOutput("len0_ready",    32'(bus.byte_ready), 32'd0);
      startLoad();
      checkOutput("restart_error", 32'(bus.error), 32'd0);
      checkOutput("restart_busy",  32'(bus.busy),  32'd1);
      applyStimulus(8'(DEPTH + 1), 1'b0);
      checkOutput("lenbig_error",      32'(bus.error),      32'd1);
      checkOutput("lenbig_word_count", 32'(bus.word_count), 32'd0);
      checkOutput("lenbig_done",       32'(bus.done),       32'd0);

      // Reset after 6 data bytes of a two-word load.
      $display("[TB] mid-load reset");
      startLoad();
      applyStimulus(8'h02, 1'b0);
      e.addr = 0;
      e.data = 32'hA1B2_C3D4;
      expQ.push_back(e);
      applyStimulus(8'hD4, 1'b0);
      applyStimulus(8'hC3, 1'b0);
      applyStimulus(8'hB2, 1'b0);
      applyStimulus(8'hA1, 1'b0);
      applyStimulus(8'h3C, 1'b0);
      applyStimulus(8'h2D, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkResetOutputs("midrst");
      checkOutput("midrst_queue_left", 32'(expQ.size()), 32'd0);
      prog = '{32'hCAFE_F00D};
      startLoad();
      loadProgram(1'b0);
      waitEnd(100, sawDone, sawErr, prevCore);
      checkOutput("postrst_done",       32'(sawDone),        32'd1);
      checkOutput("postrst_word_count", 32'(bus.word_count), 32'd1);

      // Full-depth load with start pulsed while busy.
      $display("[TB] full-depth load");
      prog.delete();
      for (int i = 0; i < DEPTH; i++) begin
         prog.push_back({8'(i), 8'h5A, 8'(255 - i), 8'(i * 7)});
      end
      base = busyCycles;
      startLoad();
      fork
         loadProgram(1'b0);
         begin
            repeat (40) @(posedge clk);
            #1;
            bus.start = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            bus.start = 1'b0;
         end
      join
      waitEnd(400, sawDone, sawErr, prevCore);
      checkOutput("full_done",       32'(sawDone),        32'd1);
      checkOutput("full_word_count", 32'(bus.word_count), 32'(DEPTH));
      checkOutput("full_latency",    32'(busyCycles - base), 32'(1 + 5 * DEPTH + CSUM_CYCLES));
      checkOutput("full_queue_left", 32'(expQ.size()),    32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
      // Wrong checksum: 13^05^10^00 = 06, so 07 must end in ERR after the write.
      $display("[TB] bad checksum");
      startLoad();
      applyStimulus(8'h01, 1'b0);
      e.addr = 0;
      e.data = 32'h0010_0513;
      expQ.push_back(e);
      applyStimulus(8'h13, 1'b0);
      applyStimulus(8'h05, 1'b0);
      applyStimulus(8'h10, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h07, 1'b0);
      checkOutput("badcsum_error",      32'(bus.error),      32'd1);
      checkOutput("badcsum_done",       32'(bus.done),       32'd0);
      checkOutput("badcsum_word_count", 32'(bus.word_count), 32'd1);
      checkOutput("badcsum_queue_left", 32'(expQ.size()),    32'd0);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
